// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: "01" preamble, LSB-first payload, optional even parity (SERIAL_FRAME_TX_PARITY_EN).
// Accept->first bit 1 cycle; tx_ready only in IDLE, so upstream is stalled for the whole frame.
module serial_frame_tx #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   output logic              out,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      PRE0,
      PRE1,
      DATA
`ifdef SERIAL_FRAME_TX_PARITY_EN
      , PAR
`endif
   } state_t;

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              out_q;
   logic              busy_q;
   logic              done_q;
`ifdef SERIAL_FRAME_TX_PARITY_EN
   logic              par_q;
`endif

   assign tx_ready = (state_q == IDLE);
   assign out      = out_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // Outputs are assigned on the edge that enters the state they belong to.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_valid) begin
                  shift_q <= tx_data;
                  cnt_q   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  par_q   <= ^tx_data;
`endif
                  state_q <= PRE0;
                  out_q   <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            PRE0: begin
               state_q <= PRE1;
               out_q   <= 1'b1;
            end
            PRE1: begin
               state_q <= DATA;
               out_q   <= shift_q[0];
               shift_q <= shift_q >> 1;
            end
            DATA: begin
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                  state_q <= PAR;
                  out_q   <= par_q;
`else
                  state_q <= IDLE;
                  out_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`endif
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
                  out_q   <= shift_q[0];
                  shift_q <= shift_q >> 1;
               end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            PAR: begin
               state_q <= IDLE;
               out_q   <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
`endif
            default: begin
               state_q <= IDLE;
               out_q   <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: table of words with hand-written expected line bits, scoreboarded per cycle.
module tb_serial_frame_tx;

`ifdef SERIAL_FRAME_TX_PARITY_EN
   localparam int FRAME_LEN = 11;
`else
   localparam int FRAME_LEN = 10;
`endif

   logic       clk;
   logic       rst;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;
   logic       out;
   logic       busy;
   logic       done;

   serial_frame_tx #(.DATA_W(8), .CNT_W(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // bits[0] is the first bit on the line (preamble 0), bits[9] the last payload bit.
   typedef struct {
      logic [7:0] data;
      logic [9:0] bits;
      logic       par;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   logic exp_q[$];
   bit   last_busy = 0;
   bit   b2b_chk   = 0;
   int   run = 0;
   int   gap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor samples 2ns after each rising edge; the driver only changes inputs on falling edges.
   always begin
      logic e;
      @(posedge clk);
      #2;
      if (!rst) begin
         chk("rst_out", out, 1);
         chk("rst_busy", busy, 0);
         chk("rst_ready", tx_ready, 1);
         chk("rst_done", done, 0);
         exp_q.delete();
         last_busy = 0;
         run = 0;
         gap = 0;
      end else if (busy) begin
         chk("ready_while_busy", tx_ready, 0);
         if (!last_busy && b2b_chk) chk("b2b_gap", gap, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("line_bit", out, e);
         end else begin
            chk("extra_busy", busy, 0);
         end
         run++;
         last_busy = 1;
      end else begin
         chk("idle_ready", tx_ready, 1);
         chk("idle_out", out, 1);
         if (last_busy) begin
            chk("done_pulse", done, 1);
            chk("frame_len", run, FRAME_LEN);
            gap = 1;
         end else begin
            chk("done_idle", done, 0);
            gap++;
         end
         run = 0;
         last_busy = 0;
      end
   end

   // Called on a falling edge; returns on the falling edge after the accept edge.
   task automatic send(input logic [7:0] d, input logic [9:0] bits, input logic par, input bit keep_valid);
      int n;
      tx_data  = d;
      tx_valid = 1'b1;
      for (n = 0; n < 100; n++) begin
         if (tx_ready === 1'b1) break;
         @(negedge clk);
      end
      if (n == 100) chk("accept_timeout", tx_ready, 1);
      for (int i = 0; i < 10; i++) exp_q.push_back(bits[i]);
`ifdef SERIAL_FRAME_TX_PARITY_EN
      exp_q.push_back(par);
`else
      if (par === 1'bx) exp_q.push_back(1'b0);
`endif
      @(negedge clk);
      if (!keep_valid) tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (busy === 1'b0 && exp_q.size() == 0) break;
      end
      if (n == 100) chk("idle_timeout", exp_q.size() + busy, 0);
      @(negedge clk);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 10'b10100101_10, 1'b0};
      vecs[1] = '{8'h07, 10'b00000111_10, 1'b1};
      vecs[2] = '{8'h00, 10'b00000000_10, 1'b0};
      vecs[3] = '{8'hFF, 10'b11111111_10, 1'b0};
      vecs[4] = '{8'h80, 10'b10000000_10, 1'b1};
      vecs[5] = '{8'h5A, 10'b01011010_10, 1'b0};

      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].data, vecs[i].bits, vecs[i].par, 1'b0);
         wait_idle();
      end

      // Back-to-back with tx_valid held high across both frames.
      send(8'h01, 10'b00000001_10, 1'b1, 1'b1);
      b2b_chk = 1;
      send(8'hFF, 10'b11111111_10, 1'b0, 1'b0);
      wait_idle();
      b2b_chk = 0;

      // Reset during the third payload bit aborts the frame without done.
      send(8'h3C, 10'b00111100_10, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send(8'h81, 10'b10000001_10, 1'b0, 1'b0);
      wait_idle();

      // Live tx_data changes while busy must not reach the line.
      send(8'hF0, 10'b11110000_10, 1'b0, 1'b0);
      tx_data = 8'h00;
      wait_idle();

      repeat (3) @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
